// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants, the IF/ID payload layout and the redirect alignment helper.
package fetch_stage_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_plus4;
    logic               valid;
  } if_id_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle capture of the fetched word; flush beats stall, stall holds everything.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [31:0]        pc_plus4_in,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_plus4_o,
  output logic               valid_o
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d.instr    = NOP_INSTR;
      if_id_d.pc_plus4 = 32'h0;
      if_id_d.valid    = 1'b0;
    end else if (!stall) begin
      if_id_d.instr    = instr_in;
      if_id_d.pc_plus4 = pc_plus4_in;
      if_id_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc_plus4 <= 32'h0;
      if_id_q.valid    <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign instr_o    = if_id_q.instr;
  assign pc_plus4_o = if_id_q.pc_plus4;
  assign valid_o    = if_id_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register with redirect/stall, imem addressing, IF/ID register and statistics.
// Instruction at pc_f lands in IF/ID one cycle later; hazard-unit stalls hold state, redirect always wins over stall_f.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic [INSTR_W-1:0] imem_rd,
  output logic [5:0]         imem_a,
  output logic [31:0]        pc_f,
  output logic [INSTR_W-1:0] instr_d,
  output logic [31:0]        pc_plus4_d,
  output logic               valid_d,
  output logic               misalign,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      pc_plus4;
  logic             load_if_id;

  assign pc_plus4   = pc_q + 32'd4;
  assign load_if_id = !flush_d && !stall_d;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = align_word(redirect_pc);
      misalign_d = |redirect_pc[1:0];
    end else if (!stall_f) begin
      pc_d = pc_plus4;
    end
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_d && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
    if (load_if_id && !(&fetch_cnt_q)) begin
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_d),
    .stall       (stall_d),
    .instr_in    (imem_rd),
    .pc_plus4_in (pc_plus4),
    .instr_o     (instr_d),
    .pc_plus4_o  (pc_plus4_d),
    .valid_o     (valid_d)
  );

  assign imem_a    = pc_q[7:2];
  assign pc_f      = pc_q;
  assign misalign  = misalign_q;
  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
